// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers (MULT/MULTU/DIV/DIVU).
// Optional MULDIV_MTHILO_EN adds mthi/mtlo/wdata direct HI/LO writes while idle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_MTHILO_EN
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start or a HI/LO write
  // CALC  | one shift-add / restoring-divide step per clock
  // FIX   | sign correction, HI/LO update
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic               wr_hi, wr_lo;
  logic [WIDTH-1:0]   wdata_i;
`ifdef MULDIV_MTHILO_EN
  assign wr_hi   = mthi;
  assign wr_lo   = mtlo;
  assign wdata_i = wdata;
`else
  assign wr_hi   = 1'b0;
  assign wr_lo   = 1'b0;
  assign wdata_i = '0;
`endif

  logic             signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign signed_op = ~op[0];
  assign abs_a = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply step: conditional add into the upper half, carry kept as the new MSB after the shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: rem < divisor always, so the kept difference fits in WIDTH bits.
  logic [WIDTH:0]     rem_s;
  logic [WIDTH-1:0]   quot_s, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
  assign rem_s    = {acc_q[2*WIDTH-1:WIDTH-1]};
  assign quot_s   = {acc_q[WIDTH-2:0], 1'b0};
  assign rem_ge   = rem_s >= {1'b0, mcand_q};
  assign rem_sub  = rem_s[WIDTH-1:0] - mcand_q;
  assign div_next = rem_ge ? {rem_sub, quot_s[WIDTH-1:1], 1'b1} : {rem_s[WIDTH-1:0], quot_s};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quot_fix = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (wr_hi || wr_lo) begin
          if (wr_hi) hi_d = wdata_i;
          if (wr_lo) lo_d = wdata_i;
        end else if (start) begin
          dbz_d    = 1'b0;
          is_div_d = op[1];
          sa_d     = signed_op & a[WIDTH-1];
          sb_d     = signed_op & b[WIDTH-1];
          if (op[1] && (b == '0)) begin
            dbz_d   = 1'b1;
            hi_d    = a;
            lo_d    = '1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(WIDTH);
            mcand_d = op[1] ? abs_b : abs_a;
            acc_d   = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, b = '0;
`ifdef MULDIV_MTHILO_EN
  logic         mthi = 1'b0, mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
`endif
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
`ifdef MULDIV_MTHILO_EN
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
`endif
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: res = 64'(sx * sy);
      2'd1: res = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    int lat_exp;
    int k;
    bit seen;
    e = ref_model(o, x, y);
    lat_exp = (o[1] && y == 0) ? 0 : 33;
    k = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    while (k < 100) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) chk("busy_during_op", 64'(busy), 64'd1);
      k++;
      @(negedge clk);
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(k), 64'(lat_exp));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("hi", 64'(hi), 64'(e[63:32]));
    chk("lo", 64'(lo), 64'(e[31:0]));
    chk("div_by_zero", 64'(dbz), 64'(o[1] && y == 0));
    // A start presented during DONE must be ignored.
    start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom | 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 64'({busy, done}), 64'd0);
    chk("hi_hold", 64'(hi), 64'(e[63:32]));
    chk("lo_hold", 64'(lo), 64'(e[31:0]));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          done_after_rst;

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd3, 32'd100, 32'd0);
    run_op(2'd1, 32'd3, 32'd4);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000);
    run_op(2'd2, 32'd7, 32'd0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'd1);
    run_op(2'd2, 32'd9, 32'hFFFF_FFFE);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op(ro, ra, rb);
    end

`ifdef MULDIV_MTHILO_EN
    @(negedge clk);
    ra = lo;
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_lo_unchanged", 64'(lo), 64'(ra));
    mthi = 1'b1; mtlo = 1'b1; start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2; wdata = 32'hCAFE_0001;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    chk("mt_both_hilo", {hi, lo}, {32'hCAFE_0001, 32'hCAFE_0001});
    chk("mt_start_ignored", 64'(busy), 64'd0);
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_busy_ignored", 64'(hi), 64'hCAFE_0001);
    repeat (40) @(negedge clk);
    chk("mult_after_busy_write", {hi, lo}, 64'd25);
`endif

    // Reset mid-operation: second start ignored, no done afterwards, all outputs cleared.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd77; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("second_start_busy", 64'({busy, dbz}), 64'b10);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_after_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_after_rst = 1'b1;
    end
    chk("no_done_after_rst", 64'(done_after_rst), 64'd0);
    chk("hilo_after_rst", {hi, lo}, 64'd0);

    run_op(2'd1, 32'd5, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit with HI/LO result registers.
- Sits beside the combinational ALU in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU requests via a start/busy/done handshake.
- Computes one radix-2 step per clock; the controller stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  WIDTH  operand 1 (rs); multiplicand or dividend
- b  input  WIDTH  operand 2 (rt); multiplier or divisor
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse; HI/LO valid and updated
- div_by_zero  output  1  sticky flag for the last DIV/DIVU with b==0; cleared on next accepted start
- hi  output  WIDTH  MULT: product[63:32]; DIV: remainder
- lo  output  WIDTH  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Internal accumulators and counter are cleared.
- Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches op, a and b at edge T.
  - Signed ops: capture |a|, |b| and the sign bits.
  - Counter loads WIDTH; go to CALC. busy=1 from T.
  - DIV/DIVU with b==0: skip CALC. Set div_by_zero=1, hi=a, lo=all ones; go to DONE.
- CALC, one iteration per cycle for WIDTH cycles:
  - Multiply: shift-add. If the LSB of the multiplier is 1, add the multiplicand to the upper accumulator; shift the 65-bit accumulator right by 1.
  - Divide: restoring. Shift the {rem,quot} pair left by 1; trial-subtract the divisor from rem; if non-negative, keep the result and set the quot LSB.
  - Go to FIX when the counter reaches 0.
- FIX (one cycle): sign correction.
  - MULT: negate the 64-bit product if sign(a)!=sign(b).
  - DIV: negate the quotient if sign(a)!=sign(b); negate the remainder if a was negative.
  - Write hi/lo; go to DONE.
- DONE (one cycle): done=1, busy=0; go to IDLE.
  - A start asserted while in DONE is ignored; the next accept happens in IDLE.
- Latency:
  - Normal case: done asserted at T+WIDTH+2 (34 cycles for WIDTH=32).
  - Divide-by-zero: done asserted at T+1.
- start while busy or in DONE: ignored; operands and results are not disturbed.
- hi/lo hold their last values in all other states; they change only on the FIX or div-by-zero edge.
- Arithmetic corner cases:
  - 0x80000000 DIV 0xFFFFFFFF gives lo=0x80000000, hi=0 (two's-complement wrap, no trap).
  - Absolute-value logic treats 0x80000000 as unsigned 2^31.
- a, b and op may change freely after the accept edge.

Optional Feature:
- Macro: MULDIV_MTHILO_EN.
- When defined, three extra inputs are added:
  - mthi (1 bit)
  - mtlo (1 bit)
  - wdata (WIDTH)
- In IDLE, mthi writes wdata to hi and mtlo writes wdata to lo at the clock edge; both may be asserted together.
- If start and mthi/mtlo are both asserted in the same cycle, the write takes effect and start is ignored that cycle.
- Writes while busy are ignored.
- When undefined, the ports do not exist and hi/lo change only through operations.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at T+34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles T..T+33.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 → done at T+1; div_by_zero=1; hi=100, lo=0xFFFFFFFF. The next MULTU 3×4 clears div_by_zero and gives lo=12, hi=0.
- Start MULTU 5×6, pulse start again with different operands at T+10, then assert rst_n=0 at T+20 → second start ignored; after reset no done pulse, hi=lo=0, busy=0.
- With MULDIV_MTHILO_EN: mthi wdata=0x12345678 in IDLE → hi=0x12345678 next cycle, lo unchanged. Same write while busy → hi unaffected.
